// File: rtl/joy_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
// The optional debounce stage is enabled by the JOY_DEBOUNCE_EN macro.
package joy_pkg;

   typedef enum logic [1:0] {
      JM_PASS  = 2'd0,
      JM_LAST  = 2'd1,
      JM_FIRST = 2'd2,
      JM_SOCD  = 2'd3
   } joy_mode_t;

   localparam int JB_RIGHT = 0;
   localparam int JB_LEFT  = 1;
   localparam int JB_DOWN  = 2;
   localparam int JB_UP    = 3;

   // One-hot of the highest set bit, so up > down > left > right on ties
   function automatic logic [3:0] hi_onehot4(input logic [3:0] v);
      logic [3:0] r;
      r = 4'b0000;
      if (v[JB_UP])         r[JB_UP]    = 1'b1;
      else if (v[JB_DOWN])  r[JB_DOWN]  = 1'b1;
      else if (v[JB_LEFT])  r[JB_LEFT]  = 1'b1;
      else if (v[JB_RIGHT]) r[JB_RIGHT] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Bundle of the per-channel mode selects and direction buses.
// Channel i: mode at [2i+1:2i], directions at [4i+3:4i].
// Macro JOY_DEBOUNCE_EN does not affect this interface.
interface joy_dir_filter_if #(
   parameter int NCH = 2
);
   logic [2*NCH-1:0] mode;
   logic [4*NCH-1:0] dir_in;
   logic [4*NCH-1:0] dir_out;
   logic [NCH-1:0]   dir_chg;

   modport master (output mode, output dir_in, input dir_out, input dir_chg);
   modport slave  (input mode, input dir_in, output dir_out, output dir_chg);
endinterface

// File: rtl/joy_dir_filter_chan.sv
// One joystick channel: 2-flop synchroniser, optional debounce (JOY_DEBOUNCE_EN),
// then the mode-dependent direction filter with a registered output.
module joy_dir_filter_chan
   import joy_pkg::*;
`ifdef JOY_DEBOUNCE_EN
#(
   parameter int DEB_CYCLES = 8,
   parameter int DEB_W      = 4
)
`endif
(
   input  logic      clk,
   input  logic      reset_n,
   input  joy_mode_t mode,
   input  logic [3:0] dir_in,
   output logic [3:0] dir_out,
   output logic       dir_chg
);

   logic [3:0] q1, q2, d, dprev, rise, mask, mask_next, out_next;
   joy_mode_t  mode_q;

   // Two-flop synchroniser bringing the raw bits into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         q1 <= dir_in;
         q2 <= q1;
      end
   end

`ifdef JOY_DEBOUNCE_EN
   logic [3:0]       deb;
   logic [DEB_W-1:0] cnt [4];

   // Per-bit debounce: a bit only follows q2 after DEB_CYCLES disagreeing cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb <= '0;
         for (int b = 0; b < 4; b++) cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (q2[b] == deb[b]) begin
               cnt[b] <= '0;
            end else if (cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
               deb[b] <= q2[b];
               cnt[b] <= '0;
            end else begin
               cnt[b] <= cnt[b] + 1'b1;
            end
         end
      end
   end

   assign d = deb;
`else
   assign d = q2;
`endif

   assign rise = d & ~dprev;

   // Filter rule; a mode switch blanks the output and mask for one update so
   // the new mode always starts from a clean, empty mask
   always_comb begin
      mask_next = mask;
      out_next  = '0;
      if (mode != mode_q) begin
         mask_next = '0;
         out_next  = '0;
      end else begin
         case (mode)
            JM_LAST: begin
               if (rise != '0)
                  mask_next = hi_onehot4(rise);
               else if ((d & mask) == '0)
                  mask_next = hi_onehot4(d);
               out_next = d & mask_next;
            end
            JM_FIRST: begin
               if ((d & mask) == '0)
                  mask_next = hi_onehot4(d);
               out_next = d & mask_next;
            end
            JM_SOCD: begin
               mask_next = '0;
               out_next  = d;
               if (d[JB_LEFT] && d[JB_RIGHT]) begin
                  out_next[JB_LEFT]  = 1'b0;
                  out_next[JB_RIGHT] = 1'b0;
               end
               if (d[JB_UP] && d[JB_DOWN]) begin
                  out_next[JB_UP]   = 1'b0;
                  out_next[JB_DOWN] = 1'b0;
               end
            end
            default: begin
               mask_next = '0;
               out_next  = d;
            end
         endcase
      end
   end

   // Filter state and registered outputs with a change pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dprev   <= '0;
         mask    <= '0;
         mode_q  <= JM_PASS;
         dir_out <= '0;
         dir_chg <= 1'b0;
      end else begin
         dprev   <= d;
         mask    <= mask_next;
         mode_q  <= mode;
         dir_out <= out_next;
         dir_chg <= (out_next != dir_out);
      end
   end

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-channel joystick direction conditioner: NCH independent channels.
// Define JOY_DEBOUNCE_EN to add the per-bit debounce stage (DEB_CYCLES, DEB_W).
module joy_dir_filter
   import joy_pkg::*;
#(
   parameter int NCH = 2
`ifdef JOY_DEBOUNCE_EN
   ,
   parameter int DEB_CYCLES = 8,
   parameter int DEB_W      = 4
`endif
)
(
   input  logic           clk,
   input  logic           reset_n,
   joy_dir_filter_if.slave bus
);

   // One fully independent filter per channel, buses packed by index
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      joy_dir_filter_chan
`ifdef JOY_DEBOUNCE_EN
         #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W))
`endif
         u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .mode    (joy_mode_t'(bus.mode[2*i +: 2])),
            .dir_in  (bus.dir_in[4*i +: 4]),
            .dir_out (bus.dir_out[4*i +: 4]),
            .dir_chg (bus.dir_chg[i])
         );
   end

endmodule
